// File: rtl/vending_machine.sv
// ---------------------------------------------------------------------------
// vending_machine
//   Single-product coin-operated vending controller. The price is fixed at
//   15 Rs. The controller accepts one coin per clock (5 Rs or 10 Rs) and
//   accumulates credit. When credit reaches the price it dispenses, and it
//   returns any excess as a change coin. An idle cycle while credit is held
//   refunds that credit.
//
// Ports
//   clk     : system clock; every state change happens on the rising edge
//   reset   : synchronous, active-high reset; discards credit without refund
//   inp     : coin code sampled each edge
//             00 = none, 01 = 5 Rs, 10 = 10 Rs, 11 = invalid (ignored)
//   out     : registered dispense pulse, high for one cycle per vend
//   change  : registered coin-return code
//             00 = none, 01 = 5 Rs, 10 = 10 Rs (11 is never driven)
// ---------------------------------------------------------------------------
module vending_machine (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] inp,
  output logic       out,
  output logic [1:0] change
);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // The state is the credit currently held. Credit of 15 Rs or more is
  // never stored, because reaching the price vends in the same transition.
  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S0;
      out    <= 1'b0;
      change <= COIN_NONE;
    end else begin
      // Both outputs are pulses. They drop every cycle unless this
      // transition drives them.
      out    <= 1'b0;
      change <= COIN_NONE;
      case (state)
        S0: begin
          case (inp)
            COIN_NONE: state <= S0;
            COIN_5:    state <= S5;
            COIN_10:   state <= S10;
            COIN_BAD:  state <= S0;
            default:   state <= S0;
          endcase
        end
        S5: begin
          case (inp)
            COIN_NONE: begin
              // An idle cycle refunds the credit held.
              state  <= S0;
              change <= COIN_5;
            end
            COIN_5:    state <= S10;
            COIN_10: begin
              state <= S0;
              out   <= 1'b1;
            end
            COIN_BAD:  state <= S5;
            default:   state <= S0;
          endcase
        end
        S10: begin
          case (inp)
            COIN_NONE: begin
              state  <= S0;
              change <= COIN_10;
            end
            COIN_5: begin
              state <= S0;
              out   <= 1'b1;
            end
            COIN_10: begin
              // 20 Rs paid: vend and return 5 Rs in the same cycle.
              state  <= S0;
              out    <= 1'b1;
              change <= COIN_5;
            end
            COIN_BAD:  state <= S10;
            default:   state <= S0;
          endcase
        end
        // An unused encoding recovers to S0 with quiet outputs.
        default: state <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// ---------------------------------------------------------------------------
// tb_vending_machine
//   Scoreboard bench for vending_machine. The driver applies one coin code
//   per cycle. A credit-in-rupees reference model predicts the registered
//   response to each code, and the driver pushes that prediction into a
//   queue. A separate monitor pops the queue after every rising edge and
//   compares the prediction with out/change.
// ---------------------------------------------------------------------------
module tb_vending_machine;

  logic       clk;
  logic       reset;
  logic [1:0] inp;
  logic       out;
  logic [1:0] change;

  vending_machine dut (
    .clk    (clk),
    .reset  (reset),
    .inp    (inp),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       o;
    logic [1:0] c;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   credit = 0;   // rupees held by the reference model
  int   step_no = 0;

  // Reference model: plain rupee arithmetic on the credit held.
  task automatic drive(input logic r, input logic [1:0] i);
    exp_t e;
    int   v;
    e.o  = 1'b0;
    e.c  = 2'b00;
    @(negedge clk);
    reset = r;
    inp   = i;
    if (r) begin
      credit = 0;
    end else if (i == 2'b11) begin
      // invalid code: credit kept, nothing returned
    end else begin
      v = (i == 2'b01) ? 5 : (i == 2'b10) ? 10 : 0;
      if (v == 0) begin
        e.c    = 2'(credit / 5);
        credit = 0;
      end else if (credit + v >= 15) begin
        e.o    = 1'b1;
        e.c    = 2'((credit + v - 15) / 5);
        credit = 0;
      end else begin
        credit = credit + v;
      end
    end
    e.id = step_no;
    step_no++;
    exp_q.push_back(e);
  endtask

  // Monitor: each registered response appears one edge after its code.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (out !== e.o) begin
        bad++;
        $display("FAIL out step=%0d got=%b want=%b", e.id, out, e.o);
      end
      total++;
      if (change !== e.c) begin
        bad++;
        $display("FAIL change step=%0d got=%b want=%b", e.id, change, e.c);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    inp   = 2'b00;

    // Reset, then an idle cycle.
    drive(1'b1, 2'b00);
    drive(1'b0, 2'b00);
    // 5 + 10: exact vend, then a new coin with no output.
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b10);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b00);           // refund of that 5 Rs
    // 5 + 5 + 10: vend with 5 Rs change, then idle with no refund.
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b10);
    drive(1'b0, 2'b00);
    // Refund paths.
    drive(1'b0, 2'b10);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b00);
    // Invalid code holds credit.
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b11);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b01);
    // 10 + 5 vend, then back-to-back 10 + 10 vend.
    drive(1'b0, 2'b10);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b10);
    drive(1'b0, 2'b10);
    // Reset mid-transaction discards credit.
    drive(1'b0, 2'b10);
    drive(1'b1, 2'b01);
    drive(1'b0, 2'b00);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      logic       r;
      logic [1:0] c;
      r = ($urandom_range(0, 39) == 0);
      c = 2'($urandom_range(0, 3));
      drive(r, c);
    end
    drive(1'b0, 2'b00);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
